stc_interp_sample_buffer: RTL and testbench

Downstream stage of the STC frame aligner that feeds the trellis detector. It accepts the aligner's paired sample stream (two complex taps per strobe, at most one strobe every other clock). On each aligner `interpolate` strobe it inserts a midpoint sample, so the trellis sees 5 outputs per 4 inputs. It buffers the result in a small FIFO and presents it on a valid/ready interface with start-of-frame and last-of-frame markers.

---
 rtl/stc_interp_pkg.sv | 43 ++++
 rtl/stc_pair_fifo.sv | 55 +++++
 rtl/stc_interp_sample_buffer.sv | 158 +++++++++++++++
 tb/tb_stc_interp_sample_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stc_interp_pkg.sv
// Shared widths, pair type and midpoint helper for the STC interpolating sample buffer.
// STC_INTERP_ROUND_EN selects round-half-up midpoints; default is floor.
package stc_interp_pkg;

  localparam int STC_SAMPLE_W      = 18;
  localparam int STC_PAIR_W        = 4 * STC_SAMPLE_W;
  localparam int STC_FRAME_OUTPUTS = 16030;

  typedef struct packed {
    logic signed [STC_SAMPLE_W-1:0] real0;
    logic signed [STC_SAMPLE_W-1:0] imag0;
    logic signed [STC_SAMPLE_W-1:0] real1;
    logic signed [STC_SAMPLE_W-1:0] imag1;
  } stc_pair_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } stc_state_e;

  // One extra bit holds the full sum, so the halved result always fits the sample width.
  function automatic logic signed [STC_SAMPLE_W-1:0] stc_mid(
    input logic signed [STC_SAMPLE_W-1:0] a,
    input logic signed [STC_SAMPLE_W-1:0] b
  );
    logic [STC_SAMPLE_W:0] sum;
    sum = {a[STC_SAMPLE_W-1], a} + {b[STC_SAMPLE_W-1], b};
`ifdef STC_INTERP_ROUND_EN
    sum = sum + {{STC_SAMPLE_W{1'b0}}, 1'b1};
`endif
    return sum[STC_SAMPLE_W:1];
  endfunction

  function automatic stc_pair_t stc_pair_mid(input stc_pair_t p, input stc_pair_t c);
    stc_pair_t m;
    m.real0 = stc_mid(p.real0, c.real0);
    m.imag0 = stc_mid(p.imag0, c.imag0);
    m.real1 = stc_mid(p.real1, c.real1);
    m.imag1 = stc_mid(p.imag1, c.imag1);
    return m;
  endfunction

endpackage

// File: rtl/stc_pair_fifo.sv
// Single-clock first-word-fall-through FIFO of sample pairs with synchronous flush.
// Head visible the cycle after the first push; push into a full FIFO is dropped unless a pop coincides.
module stc_pair_fifo
  import stc_interp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [STC_PAIR_W-1:0]   push_dat,
  input  logic                    pop,
  output logic [STC_PAIR_W-1:0]   head_dat,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  fill
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);

  logic [STC_PAIR_W-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_q;
  logic [AW:0]           rd_q;
  logic                  do_push;
  logic                  do_pop;

  assign fill     = wr_q - rd_q;
  assign full     = (fill == (AW + 1)'(DEPTH));
  assign empty    = (fill == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      // A push alongside a flush lands as the sole entry.
      rd_q <= '0;
      wr_q <= push ? ONE : '0;
      if (push) mem_q[0] <= push_dat;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= push_dat;
        wr_q                <= wr_q + ONE;
      end
      if (do_pop) rd_q <= rd_q + ONE;
    end
  end

endmodule

// File: rtl/stc_interp_sample_buffer.sv
// Inserts midpoint pairs on interpolate strobes and queues them for the trellis (FWFT, 1-cycle latency).
// Holds output under out_ready=0; drops on full or pending collision into sticky overflow. Rounding via STC_INTERP_ROUND_EN.
module stc_interp_sample_buffer
  import stc_interp_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int FRAME_OUTPUTS = STC_FRAME_OUTPUTS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clkEn,
  input  logic                           sampleEn,
  input  logic                           interpolate,
  input  logic                           startOfTrellis,
  input  logic signed [STC_SAMPLE_W-1:0] dinReal0,
  input  logic signed [STC_SAMPLE_W-1:0] dinImag0,
  input  logic signed [STC_SAMPLE_W-1:0] dinReal1,
  input  logic signed [STC_SAMPLE_W-1:0] dinImag1,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic signed [STC_SAMPLE_W-1:0] doutReal0,
  output logic signed [STC_SAMPLE_W-1:0] doutImag0,
  output logic signed [STC_SAMPLE_W-1:0] doutReal1,
  output logic signed [STC_SAMPLE_W-1:0] doutImag1,
  output logic                           out_sof,
  output logic                           out_last,
  output logic                           overflow,
  output logic [$clog2(DEPTH):0]         fill
);

  localparam logic [14:0] LAST_CNT = 15'(FRAME_OUTPUTS - 1);

  stc_state_e  state_q, state_d;
  stc_pair_t   prev_q, prev_d;
  stc_pair_t   pend_q, pend_d;
  logic        prev_vld_q, prev_vld_d;
  logic [14:0] cnt_q, cnt_d;
  logic        sof_armed_q, sof_armed_d;
  logic        ovf_q, ovf_d;

  stc_pair_t   cur;
  stc_pair_t   push_dat;
  stc_pair_t   head;
  logic        wr_ev;
  logic        sot;
  logic        push;
  logic        pop;
  logic        collide;
  logic        full;
  logic        empty;

  assign cur   = {dinReal0, dinImag0, dinReal1, dinImag1};
  assign wr_ev = clkEn & sampleEn;
  assign sot   = clkEn & startOfTrellis;
  assign pop   = out_valid & out_ready & clkEn;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    pend_d     = pend_q;
    push       = 1'b0;
    push_dat   = cur;
    collide    = 1'b0;
    if (sot) begin
      state_d    = ST_IDLE;
      prev_vld_d = 1'b0;
      if (wr_ev) begin
        push       = 1'b1;
        prev_d     = cur;
        prev_vld_d = 1'b1;
      end
    end else if (state_q == ST_PEND) begin
      // The held sample always goes out; a new strobe here is the one that is lost.
      if (clkEn) begin
        push     = 1'b1;
        push_dat = pend_q;
        state_d  = ST_IDLE;
        collide  = wr_ev;
      end
      if (wr_ev) begin
        prev_d     = cur;
        prev_vld_d = 1'b1;
      end
    end else if (wr_ev) begin
      push       = 1'b1;
      prev_d     = cur;
      prev_vld_d = 1'b1;
      if (interpolate && prev_vld_q) begin
        push_dat = stc_pair_mid(prev_q, cur);
        pend_d   = cur;
        state_d  = ST_PEND;
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    sof_armed_d = sof_armed_q;
    ovf_d       = ovf_q;
    if (sot) begin
      cnt_d       = '0;
      sof_armed_d = 1'b1;
      ovf_d       = 1'b0;
    end else begin
      if (pop) begin
        cnt_d       = (cnt_q == LAST_CNT) ? '0 : cnt_q + 15'd1;
        sof_armed_d = 1'b0;
      end
      if (collide || (push && full && !pop)) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      pend_q      <= '0;
      prev_vld_q  <= 1'b0;
      cnt_q       <= '0;
      sof_armed_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      pend_q      <= pend_d;
      prev_vld_q  <= prev_vld_d;
      cnt_q       <= cnt_d;
      sof_armed_q <= sof_armed_d;
      ovf_q       <= ovf_d;
    end
  end

  stc_pair_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (sot),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .full     (full),
    .empty    (empty),
    .fill     (fill)
  );

  assign out_valid = ~empty;
  assign doutReal0 = head.real0;
  assign doutImag0 = head.imag0;
  assign doutReal1 = head.real1;
  assign doutImag1 = head.imag1;
  assign out_sof   = out_valid & sof_armed_q;
  assign out_last  = out_valid & (cnt_q == LAST_CNT);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_stc_interp_sample_buffer.sv
// Directed bench for stc_interp_sample_buffer: queue-based reference model plus literal spot checks.
module tb_stc_interp_sample_buffer;

  localparam int DEPTH = 8;
  localparam int FO    = 10;
`ifdef STC_INTERP_ROUND_EN
  localparam int MID1 = 201;
  localparam int MID2 = 0;
`else
  localparam int MID1 = 200;
  localparam int MID2 = -1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clkEn = 1'b1;
  logic sampleEn = 1'b0;
  logic interpolate = 1'b0;
  logic startOfTrellis = 1'b0;
  logic out_ready = 1'b0;
  logic signed [17:0] dinReal0 = '0;
  logic signed [17:0] dinImag0 = '0;
  logic signed [17:0] dinReal1 = '0;
  logic signed [17:0] dinImag1 = '0;
  logic out_valid, out_sof, out_last, overflow;
  logic signed [17:0] doutReal0, doutImag0, doutReal1, doutImag1;
  logic [3:0] fill;

  always #5 clk = ~clk;

  stc_interp_sample_buffer #(.DEPTH(DEPTH), .FRAME_OUTPUTS(FO)) dut (
    .clk(clk), .reset(reset), .clkEn(clkEn), .sampleEn(sampleEn),
    .interpolate(interpolate), .startOfTrellis(startOfTrellis),
    .dinReal0(dinReal0), .dinImag0(dinImag0), .dinReal1(dinReal1), .dinImag1(dinImag1),
    .out_ready(out_ready), .out_valid(out_valid),
    .doutReal0(doutReal0), .doutImag0(doutImag0), .doutReal1(doutReal1), .doutImag1(doutImag1),
    .out_sof(out_sof), .out_last(out_last), .overflow(overflow), .fill(fill)
  );

  typedef struct {int r0; int i0; int r1; int i1;} mpair_t;
  typedef struct {int r0; logic sof; logic last;} obs_t;

  mpair_t mq[$];
  mpair_t m_prev, m_pend, m_cur, m_pv;
  bit     m_prev_v = 0, m_pend_v = 0, m_ovf = 0, m_sof = 0, m_have, m_pop;
  int     m_cnt = 0;
  obs_t   log_q[$];
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mid(input int a, input int b);
    int s = a + b;
`ifdef STC_INTERP_ROUND_EN
    s = s + 1;
`endif
    return s >>> 1;
  endfunction

  function automatic mpair_t pmid(input mpair_t p, input mpair_t c);
    mpair_t m;
    m.r0 = mid(p.r0, c.r0); m.i0 = mid(p.i0, c.i0);
    m.r1 = mid(p.r1, c.r1); m.i1 = mid(p.i1, c.i1);
    return m;
  endfunction

  // Reference model: spec-level queue of expected outputs.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete(); m_prev_v = 0; m_pend_v = 0; m_ovf = 0; m_sof = 0; m_cnt = 0;
    end else if (clkEn) begin
      m_cur = '{int'(dinReal0), int'(dinImag0), int'(dinReal1), int'(dinImag1)};
      m_pop = (mq.size() > 0) && out_ready;
      if (startOfTrellis) begin
        mq.delete(); m_pend_v = 0; m_prev_v = 0; m_cnt = 0; m_ovf = 0; m_sof = 1;
        if (sampleEn) begin mq.push_back(m_cur); m_prev = m_cur; m_prev_v = 1; end
      end else begin
        if (m_pop) begin
          void'(mq.pop_front());
          m_cnt = (m_cnt == FO - 1) ? 0 : m_cnt + 1;
          m_sof = 0;
        end
        m_have = 0;
        if (m_pend_v) begin
          m_pv = m_pend; m_have = 1; m_pend_v = 0;
          if (sampleEn) begin m_ovf = 1; m_prev = m_cur; m_prev_v = 1; end
        end else if (sampleEn) begin
          if (interpolate && m_prev_v) begin
            m_pv = pmid(m_prev, m_cur); m_pend = m_cur; m_pend_v = 1;
          end else m_pv = m_cur;
          m_prev = m_cur; m_prev_v = 1; m_have = 1;
        end
        if (m_have) begin
          if (mq.size() < DEPTH) mq.push_back(m_pv);
          else m_ovf = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of accepted outputs.
  always @(negedge clk) begin
    if (reset) begin
      chk("valid", out_valid, mq.size() != 0);
      chk("fill", fill, mq.size());
      chk("overflow", overflow, m_ovf);
      if (mq.size() != 0) begin
        chk("real0", doutReal0, mq[0].r0);
        chk("imag0", doutImag0, mq[0].i0);
        chk("real1", doutReal1, mq[0].r1);
        chk("imag1", doutImag1, mq[0].i1);
        chk("sof", out_sof, m_sof);
        chk("last", out_last, m_cnt == FO - 1);
      end
      if (out_valid && out_ready && clkEn)
        log_q.push_back('{r0: int'(doutReal0), sof: out_sof, last: out_last});
    end
  end

  task automatic cycp(input bit se, input bit ip, input bit sot, input bit rdy,
                      input int r0, input int i0, input int r1, input int i1);
    sampleEn = se; interpolate = ip; startOfTrellis = sot; out_ready = rdy;
    dinReal0 = 18'(r0); dinImag0 = 18'(i0); dinReal1 = 18'(r1); dinImag1 = 18'(i1);
    @(posedge clk); #1;
  endtask

  task automatic cyc(input bit se, input bit ip, input bit sot, input bit rdy, input int r0);
    cycp(se, ip, sot, rdy, r0, r0 + 3, 1000 - r0, -r0);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cyc(0, 0, 0, rdy, 0);
  endtask

  task automatic strobe(input int r0, input bit ip, input bit rdy);
    cyc(1, ip, 0, rdy, r0);
    cyc(0, 0, 0, rdy, 0);
  endtask

  function automatic int lr0(input int k);
    return (k < log_q.size()) ? log_q[k].r0 : -999999;
  endfunction
  function automatic int lsof(input int k);
    return (k < log_q.size()) ? int'(log_q[k].sof) : -1;
  endfunction
  function automatic int llast(input int k);
    return (k < log_q.size()) ? int'(log_q[k].last) : -1;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sof", out_sof, 0);
    chk("rst_last", out_last, 0);
    chk("rst_dout", doutReal0, 0);
    reset = 1'b1;
    idle(1, 1);

    // Plain flow
    cyc(0, 0, 1, 1, 0);
    log_q.delete();
    for (int k = 1; k <= 4; k++) strobe(100 * k, 0, 1);
    idle(3, 1);
    chk("plain_count", log_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("plain_val", lr0(k), 100 * (k + 1));
      chk("plain_sof", lsof(k), k == 0);
    end

    // Interpolated midpoint
    log_q.delete();
    strobe(100, 0, 1);
    strobe(301, 1, 1);
    idle(3, 1);
    chk("interp_count", log_q.size(), 3);
    chk("interp_prev", lr0(0), 100);
    chk("interp_mid", lr0(1), MID1);
    chk("interp_cur", lr0(2), 301);

    // Extremes; third output is frame index 9
    log_q.delete();
    cycp(1, 0, 0, 1, -131072, -131072, 0, 0);
    idle(1, 1);
    cycp(1, 1, 0, 1, 131071, 131071, 0, 0);
    idle(3, 1);
    chk("ext_mid", lr0(1), MID2);
    chk("ext_cur", lr0(2), 131071);
    chk("ext_last", llast(2), 1);

    // Backpressure
    cyc(0, 0, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      strobe(10 * k, 0, 0);
      if (k == 8) begin chk("bp_fill8", fill, 8); chk("bp_ovf8", overflow, 0); end
      if (k == 9) begin chk("bp_fill9", fill, 8); chk("bp_ovf9", overflow, 1); end
    end
    log_q.delete();
    idle(12, 1);
    chk("bp_count", log_q.size(), 8);
    for (int k = 0; k < 8; k++) chk("bp_val", lr0(k), 10 * (k + 1));

    // Collision
    cyc(0, 0, 1, 1, 0);
    log_q.delete();
    strobe(500, 0, 1);
    cyc(1, 1, 0, 1, 700);
    cyc(1, 0, 0, 1, 900);
    idle(3, 1);
    chk("col_ovf", overflow, 1);
    chk("col_count", log_q.size(), 3);
    chk("col_mid", lr0(1), 600);
    chk("col_pend", lr0(2), 700);

    // Frame markers and wrap
    cyc(0, 0, 1, 1, 0);
    log_q.delete();
    for (int k = 0; k < 12; k++) strobe(k + 1, 0, 1);
    idle(3, 1);
    chk("frame_count", log_q.size(), 12);
    for (int k = 0; k < 12; k++) begin
      chk("frame_last", llast(k), k == 9);
      chk("frame_sof", lsof(k), k == 0);
    end

    // Restart with queued data and a concurrent strobe
    cyc(0, 0, 1, 0, 0);
    strobe(11, 0, 0);
    cyc(1, 1, 0, 0, 22);
    cyc(1, 0, 0, 0, 33);
    idle(1, 0);
    chk("sot_pre_fill", fill, 3);
    chk("sot_pre_ovf", overflow, 1);
    cyc(1, 0, 1, 0, 55);
    chk("sot_fill", fill, 1);
    chk("sot_ovf", overflow, 0);
    chk("sot_sof", out_sof, 1);
    chk("sot_val", doutReal0, 55);
    clkEn = 1'b0;
    cyc(1, 1, 0, 1, 77);
    cyc(1, 0, 1, 1, 88);
    chk("freeze_fill", fill, 1);
    chk("freeze_val", doutReal0, 55);
    clkEn = 1'b1;
    log_q.delete();
    idle(3, 1);
    chk("sot_count", log_q.size(), 1);
    chk("sot_out", lr0(0), 55);
    chk("sot_out_sof", lsof(0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
